// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding IF/ID over a req/ack memory handshake; an ack forwards combinationally (0 extra cycles).
// A downstream stall parks one instruction in a hold buffer; redirects discard in-flight data.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        flush_o
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic [31:0] redir_pc;
  logic [31:0] pc_next;
  logic        unused_redir_lsbs;

  assign redir_pc          = {redirect_pc_i[31:2], 2'b00};
  assign pc_next           = fetch_pc_q + PC_STEP[31:0];
  assign unused_redir_lsbs = ^redirect_pc_i[1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= 32'h0;
      buf_instr_q <= 32'hFFFF_FFFF;
      buf_pc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_pc_d   = pend_pc_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    imem_req_o  = 1'b0;
    valid_o     = 1'b0;
    pc_o        = 32'h0;
    instr_o     = 32'hFFFF_FFFF;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_i) fetch_pc_d = redir_pc;
      end

      FETCH: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          if (imem_ack_i) begin
            fetch_pc_d = redir_pc;
          end else begin
            // Request cannot be withdrawn: park the target until the stale ack lands.
            pend_pc_d = redir_pc;
            state_d   = DROP;
          end
        end else if (imem_ack_i) begin
          valid_o    = 1'b1;
          pc_o       = pc_next;
          instr_o    = imem_data_i;
          fetch_pc_d = pc_next;
          if (stall_i) begin
            buf_instr_d = imem_data_i;
            buf_pc_d    = pc_next;
            state_d     = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_i) begin
          fetch_pc_d = redir_pc;
          state_d    = FETCH;
        end else begin
          valid_o = 1'b1;
          pc_o    = buf_pc_q;
          instr_o = buf_instr_q;
          if (!stall_i) state_d = FETCH;
        end
      end

      DROP: begin
        imem_req_o = 1'b1;
        if (redirect_i) pend_pc_d = redir_pc;
        if (imem_ack_i) begin
          fetch_pc_d = redirect_i ? redir_pc : pend_pc_q;
          state_d    = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign imem_addr_o = fetch_pc_q;
  assign flush_o     = ~valid_o;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, async-reset sequence, randomized run vs reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic        flush_o;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .valid_o       (valid_o),
    .flush_o       (flush_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ack;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Full output check; the address only matters while a request is up.
  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_vld, input logic [31:0] e_pc, input logic [31:0] e_instr);
    chk({tag, ".req"}, {31'h0, imem_req_o}, {31'h0, e_req});
    if (e_req) chk({tag, ".addr"}, imem_addr_o, e_addr);
    chk({tag, ".valid"}, {31'h0, valid_o}, {31'h0, e_vld});
    chk({tag, ".flush"}, {31'h0, flush_o}, {31'h0, ~e_vld});
    chk({tag, ".pc"}, pc_o, e_pc);
    chk({tag, ".instr"}, instr_o, e_instr);
  endtask

  // Reference model state: where the next fetch goes and what the stage is waiting on.
  logic        m_startup, m_held, m_orphan;
  logic [31:0] m_pc, m_target, m_hold_pc, m_hold_instr;

  task automatic model_reset();
    m_startup = 1'b1; m_held = 1'b0; m_orphan = 1'b0;
    m_pc = 32'h0; m_target = 32'h0; m_hold_pc = 32'h0; m_hold_instr = 32'h0;
  endtask

  initial begin
    logic        r_ack, r_stall, r_redir, e_req, e_vld;
    logic [31:0] r_rpc, r_tgt, r_data, e_pc, e_instr;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h4,   32'hA5A5_A5A5};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 32'h8,   32'hA5A5_A5A1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'hC,   32'hA5A5_A5AD};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hC,   32'hA5A5_A5AD};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hC,   32'hA5A5_A5AD};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hC,   32'hA5A5_A5AD};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h10,  32'hA5A5_A5A9};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h103,      1'b1, 32'h10,       1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h200,      1'b1, 32'h100,      1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h300,      1'b1, 32'h100,      1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h300,      1'b1, 32'h304, 32'hA5A5_A6A5};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       1'b1, 32'h44,  32'hA5A5_A5E5};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h44,      1'b0, 32'h0,   32'hFFFF_FFFF};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0,  32'h5A5A_5A59};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 32'h4,   32'hA5A5_A5A5};

    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_all("rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    // Directed table: zero-wait stream, stall/HOLD, DROP, double redirect, HOLD redirect, wrap
    for (int i = 0; i < 20; i++) begin
      imem_ack_i    = tbl[i].ack;
      stall_i       = tbl[i].stall;
      redirect_i    = tbl[i].redir;
      redirect_pc_i = tbl[i].rpc;
      imem_data_i   = tbl[i].ack ? (imem_addr_o ^ K) : 32'h0;
      @(negedge clk_i);
      chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_vld, tbl[i].e_pc, tbl[i].e_instr);
      @(posedge clk_i); #1;
    end

    // Async reset mid-request of 0x20, with a stale ack during and after reset
    imem_ack_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h20;
    imem_data_i = imem_addr_o ^ K;
    @(negedge clk_i);
    chk_all("ar.redir", 1'b1, 32'h4, 1'b0, 32'h0, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    imem_ack_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    @(negedge clk_i);
    chk_all("ar.req20", 1'b1, 32'h20, 1'b0, 32'h0, 32'hFFFF_FFFF);
    #1;
    rst_n_i = 1'b0;
    imem_ack_i = 1'b1; imem_data_i = 32'h20 ^ K;
    #1;
    chk_all("ar.inrst", 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk_all("ar.stale", 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    imem_ack_i = 1'b0;
    @(negedge clk_i);
    chk_all("ar.restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFFF);
    @(posedge clk_i); #1;
    imem_ack_i = 1'b1; imem_data_i = imem_addr_o ^ K;
    @(negedge clk_i);
    chk_all("ar.first", 1'b1, 32'h0, 1'b1, 32'h4, 32'hA5A5_A5A5);

    // Randomized run against the reference model
    #1;
    rst_n_i = 1'b0; imem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      r_stall = ($urandom_range(0, 9) < 3);
      r_redir = ($urandom_range(0, 99) < 8);
      r_rpc   = $urandom;
      r_tgt   = {r_rpc[31:2], 2'b00};
      if ($urandom_range(0, 99) < 3) r_tgt = 32'hFFFF_FFFC;
      if (r_tgt == 32'hFFFF_FFFC) r_rpc = r_tgt | 32'h3;
      e_req  = !m_startup && !m_held;
      r_ack  = e_req && ($urandom_range(0, 9) < 6);
      r_data = r_ack ? (m_pc ^ K) : $urandom;

      e_vld = 1'b0; e_pc = 32'h0; e_instr = 32'hFFFF_FFFF;
      if (!r_redir) begin
        if (m_held) begin
          e_vld = 1'b1; e_pc = m_hold_pc; e_instr = m_hold_instr;
        end else if (e_req && !m_orphan && r_ack) begin
          e_vld = 1'b1; e_pc = m_pc + 32'd4; e_instr = r_data;
        end
      end

      imem_ack_i = r_ack; imem_data_i = r_data; stall_i = r_stall;
      redirect_i = r_redir; redirect_pc_i = r_rpc;
      @(negedge clk_i);
      chk_all("rnd", e_req, m_pc, e_vld, e_pc, e_instr);

      if (m_startup) begin
        m_startup = 1'b0;
        if (r_redir) m_pc = r_tgt;
      end else if (m_held) begin
        if (r_redir) begin m_held = 1'b0; m_pc = r_tgt; end
        else if (!r_stall) m_held = 1'b0;
      end else if (m_orphan) begin
        if (r_redir) m_target = r_tgt;
        if (r_ack) begin m_orphan = 1'b0; m_pc = m_target; end
      end else if (r_redir) begin
        if (r_ack) m_pc = r_tgt;
        else begin m_orphan = 1'b1; m_target = r_tgt; end
      end else if (r_ack) begin
        if (r_stall) begin
          m_held = 1'b1; m_hold_pc = m_pc + 32'd4; m_hold_instr = r_data;
        end
        m_pc = m_pc + 32'd4;
      end
      @(posedge clk_i); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
